sd_cmd_xfer: RTL and testbench

Parametrised SD command-line engine that succeeds the single-format command engine. It serialises 48-bit commands onto CMD and paces every bit off an SD-clock tick strobe. It receives no-response, R1, R1b (with DAT0 busy wait), R2 (136-bit) and R3 responses, and enforces the N_CC inter-command gap. It also supports mid-transfer abort. It sits between the register/sequencer layer and the pad tristate, sharing the tick from the clock generator with the data engine.

---
 rtl/sd_cmd_pkg.sv | 42 ++++
 rtl/sd_crc7_serial.sv | 34 +++
 rtl/sd_cmd_xfer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_sd_cmd_xfer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command-line engine.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        RESP_NONE = 3'd0,
        RESP_R1   = 3'd1,
        RESP_R1B  = 3'd2,
        RESP_R2   = 3'd3,
        RESP_R3   = 3'd4
    } resp_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RESP,
        ST_RECV,
        ST_BUSY,
        ST_GAP
    } state_t;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_CRC     = 1;
    localparam int ERR_END     = 2;
    localparam int ERR_INDEX   = 3;
    localparam int ERR_BUSY    = 4;
    localparam int ERR_ABORT   = 5;

    localparam int CMD_BITS = 48;
    localparam int R2_BITS  = 136;

    // Unknown encodings fall back to "no response".
    function automatic resp_type_t decode_resp(input logic [2:0] raw);
        case (raw)
            3'd1:    return RESP_R1;
            3'd2:    return RESP_R1B;
            3'd3:    return RESP_R2;
            3'd4:    return RESP_R3;
            default: return RESP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB-first, clear has priority over enable.
module sd_crc7_serial (
    input  logic       PCLK_i,
    input  logic       PRESET_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = bit_i ^ crc_q[6];
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
    end

    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_xfer.sv
// SD CMD-line engine: serialises 48-bit commands, receives R1/R1b/R2/R3,
// waits out DAT0 busy and enforces the inter-command gap, all paced by sd_tick_i.
module sd_cmd_xfer
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT_W = 16,
    parameter int BUSY_W    = 24,
    parameter int NCC_TICKS = 8
) (
    input  logic                 PCLK_i,
    input  logic                 PRESET_i,
    input  logic                 sd_tick_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [5:0]           cmd_index_i,
    input  logic [31:0]          cmd_arg_i,
    input  logic [2:0]           resp_type_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    input  logic [BUSY_W-1:0]    busy_limit_i,
    input  logic                 abort_i,
    output logic                 cmd_o,
    output logic                 cmd_oe_o,
    input  logic                 cmd_i,
    input  logic                 dat0_i,
    output logic                 done_o,
    output logic [127:0]         resp_o,
    output logic [5:0]           err_o
);

    localparam int CNT_W = (BUSY_W > TIMEOUT_W) ? BUSY_W : TIMEOUT_W;

    state_t               state_q, state_d;
    resp_type_t           rtype_q, rtype_d;
    logic [5:0]           idx_q, idx_d;
    logic [31:0]          arg_q, arg_d;
    logic [TIMEOUT_W-1:0] tmo_lim_q, tmo_lim_d;
    logic [BUSY_W-1:0]    busy_lim_q, busy_lim_d;
    logic [7:0]           bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [126:0]         rx_q, rx_d;
    logic                 cmd_o_q, cmd_o_d, cmd_oe_q, cmd_oe_d, done_q, done_d;
    logic [127:0]         resp_q, resp_d;
    logic [5:0]           err_q, err_d;

    logic                 tx_crc_clr, tx_crc_en, rx_crc_clr, rx_crc_en;
    logic [6:0]           tx_crc, rx_crc;
    logic [7:0]           bit_pos;
    logic [CNT_W-1:0]     tick_inc;
    logic [47:0]          tx_pkt;
    logic                 tx_bit;
    logic [127:0]         rx_full;
    logic [5:0]           chk_err;

    // CRC bits 7..1 are read from the TX CRC only after bits 47..8 have been fed in.
    assign tx_pkt   = {1'b0, 1'b1, idx_q, arg_q, tx_crc, 1'b1};
    assign bit_pos  = bit_cnt_q - 8'd1;
    assign tx_bit   = tx_pkt[bit_pos[5:0]];
    assign tick_inc = (tick_cnt_q == '1) ? tick_cnt_q : tick_cnt_q + CNT_W'(1);
    assign rx_full  = {rx_q, cmd_i};

    sd_crc7_serial u_tx_crc (
        .PCLK_i  (PCLK_i),
        .PRESET_i(PRESET_i),
        .clr_i   (tx_crc_clr),
        .en_i    (tx_crc_en),
        .bit_i   (tx_bit),
        .crc_o   (tx_crc)
    );

    sd_crc7_serial u_rx_crc (
        .PCLK_i  (PCLK_i),
        .PRESET_i(PRESET_i),
        .clr_i   (rx_crc_clr),
        .en_i    (rx_crc_en),
        .bit_i   (cmd_i),
        .crc_o   (rx_crc)
    );

    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) begin
            state_q    <= ST_IDLE;
            rtype_q    <= RESP_NONE;
            idx_q      <= '0;
            arg_q      <= '0;
            tmo_lim_q  <= '0;
            busy_lim_q <= '0;
            bit_cnt_q  <= '0;
            tick_cnt_q <= '0;
            rx_q       <= '0;
            cmd_o_q    <= 1'b1;
            cmd_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            resp_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            rtype_q    <= rtype_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            tmo_lim_q  <= tmo_lim_d;
            busy_lim_q <= busy_lim_d;
            bit_cnt_q  <= bit_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            rx_q       <= rx_d;
            cmd_o_q    <= cmd_o_d;
            cmd_oe_q   <= cmd_oe_d;
            done_q     <= done_d;
            resp_q     <= resp_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rtype_d    = rtype_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        tmo_lim_d  = tmo_lim_q;
        busy_lim_d = busy_lim_q;
        bit_cnt_d  = bit_cnt_q;
        tick_cnt_d = tick_cnt_q;
        rx_d       = rx_q;
        cmd_o_d    = cmd_o_q;
        cmd_oe_d   = cmd_oe_q;
        done_d     = 1'b0;
        resp_d     = resp_q;
        err_d      = err_q;
        tx_crc_clr = 1'b0;
        tx_crc_en  = 1'b0;
        rx_crc_clr = 1'b0;
        rx_crc_en  = 1'b0;
        chk_err    = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    idx_d      = cmd_index_i;
                    arg_d      = cmd_arg_i;
                    rtype_d    = decode_resp(resp_type_i);
                    tmo_lim_d  = timeout_i;
                    busy_lim_d = busy_limit_i;
                    bit_cnt_d  = 8'(CMD_BITS);
                    tx_crc_clr = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (sd_tick_i) begin
                    if (bit_cnt_q != 8'd0) begin
                        cmd_o_d   = tx_bit;
                        cmd_oe_d  = 1'b1;
                        bit_cnt_d = bit_pos;
                        tx_crc_en = (bit_pos >= 8'd8);
                    end else begin
                        cmd_o_d    = 1'b1;
                        cmd_oe_d   = 1'b0;
                        tick_cnt_d = '0;
                        if (rtype_q == RESP_NONE) begin
                            done_d  = 1'b1;
                            resp_d  = '0;
                            err_d   = '0;
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_WAIT_RESP;
                        end
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (sd_tick_i) begin
                    if (!cmd_i) begin
                        rx_d       = '0;
                        rx_crc_clr = 1'b1;
                        bit_cnt_d  = (rtype_q == RESP_R2) ? 8'(R2_BITS - 1) : 8'(CMD_BITS - 1);
                        state_d    = ST_RECV;
                    end else begin
                        tick_cnt_d = tick_inc;
                        if (tick_inc >= CNT_W'(tmo_lim_q)) begin
                            err_d              = '0;
                            err_d[ERR_TIMEOUT] = 1'b1;
                            resp_d             = '0;
                            done_d             = 1'b1;
                            tick_cnt_d         = '0;
                            state_d            = ST_GAP;
                        end
                    end
                end
            end
            ST_RECV: begin
                if (sd_tick_i) begin
                    rx_d      = rx_full[126:0];
                    bit_cnt_d = bit_pos;
                    rx_crc_en = (bit_pos >= 8'd8) &&
                                ((rtype_q != RESP_R2) || (bit_pos <= 8'd127));
                    if (bit_cnt_q == 8'd1) begin
                        // All checks are evaluated together on the end-bit tick.
                        chk_err[ERR_END] = !rx_full[0];
                        if (rtype_q == RESP_R1 || rtype_q == RESP_R1B) begin
                            chk_err[ERR_CRC]   = (rx_crc != rx_full[7:1]);
                            chk_err[ERR_INDEX] = (rx_full[45:40] != idx_q);
                        end else if (rtype_q == RESP_R2) begin
                            chk_err[ERR_CRC] = (rx_crc != rx_full[7:1]);
                        end
                        tick_cnt_d = '0;
                        if (rtype_q == RESP_R1B && chk_err == 6'd0) begin
                            state_d = ST_BUSY;
                        end else begin
                            err_d   = chk_err;
                            resp_d  = (rtype_q == RESP_R2) ? rx_full : {90'd0, rx_full[45:8]};
                            done_d  = 1'b1;
                            state_d = ST_GAP;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (sd_tick_i) begin
                    tick_cnt_d = tick_inc;
                    // The first tick after the end bit never terminates busy.
                    if (tick_cnt_q != '0 && dat0_i) begin
                        err_d      = '0;
                        resp_d     = {90'd0, rx_q[45:8]};
                        done_d     = 1'b1;
                        tick_cnt_d = '0;
                        state_d    = ST_GAP;
                    end else if (tick_inc >= CNT_W'(busy_lim_q)) begin
                        err_d           = '0;
                        err_d[ERR_BUSY] = 1'b1;
                        resp_d          = {90'd0, rx_q[45:8]};
                        done_d          = 1'b1;
                        tick_cnt_d      = '0;
                        state_d         = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (sd_tick_i) begin
                    tick_cnt_d = tick_inc;
                    if (tick_inc >= CNT_W'(NCC_TICKS)) begin
                        tick_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides whatever the active state decided this cycle.
        if (abort_i && (state_q inside {ST_SEND, ST_WAIT_RESP, ST_RECV, ST_BUSY})) begin
            cmd_o_d          = 1'b1;
            cmd_oe_d         = 1'b0;
            err_d            = '0;
            err_d[ERR_ABORT] = 1'b1;
            resp_d           = '0;
            done_d           = 1'b1;
            tick_cnt_d       = '0;
            state_d          = ST_GAP;
        end
    end

    always_comb begin
        cmd_ready_o = (state_q == ST_IDLE) && !PRESET_i;
        cmd_o       = cmd_o_q;
        cmd_oe_o    = cmd_oe_q;
        done_o      = done_q;
        resp_o      = resp_q;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_sd_cmd_xfer.sv
// Directed bench for sd_cmd_xfer: card-side CMD/DAT0 driver plus wire/done monitors.
module tb_sd_cmd_xfer;

    logic         PCLK_i       = 1'b0;
    logic         PRESET_i     = 1'b1;
    logic         sd_tick_i    = 1'b0;
    logic         cmd_valid_i  = 1'b0;
    logic         cmd_ready_o;
    logic [5:0]   cmd_index_i  = '0;
    logic [31:0]  cmd_arg_i    = '0;
    logic [2:0]   resp_type_i  = '0;
    logic [15:0]  timeout_i    = '0;
    logic [23:0]  busy_limit_i = '0;
    logic         abort_i      = 1'b0;
    logic         cmd_o, cmd_oe_o;
    logic         cmd_i        = 1'b1;
    logic         dat0_i       = 1'b1;
    logic         done_o;
    logic [127:0] resp_o;
    logic [5:0]   err_o;

    sd_cmd_xfer #(.TIMEOUT_W(16), .BUSY_W(24), .NCC_TICKS(8)) dut (
        .PCLK_i      (PCLK_i),
        .PRESET_i    (PRESET_i),
        .sd_tick_i   (sd_tick_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_index_i (cmd_index_i),
        .cmd_arg_i   (cmd_arg_i),
        .resp_type_i (resp_type_i),
        .timeout_i   (timeout_i),
        .busy_limit_i(busy_limit_i),
        .abort_i     (abort_i),
        .cmd_o       (cmd_o),
        .cmd_oe_o    (cmd_oe_o),
        .cmd_i       (cmd_i),
        .dat0_i      (dat0_i),
        .done_o      (done_o),
        .resp_o      (resp_o),
        .err_o       (err_o)
    );

    always #5 PCLK_i = ~PCLK_i;

    // One tick every 4 PCLK.
    logic [1:0] tick_div = 2'd0;
    always @(posedge PCLK_i) begin
        tick_div  <= tick_div + 2'd1;
        sd_tick_i <= (tick_div == 2'd3);
    end

    int           tick_total = 0, tx_cnt = 0, tx_last_tick = 0;
    int           done_cnt = 0, done_tick = 0, accept_tick = 0, overlap_cnt = 0;
    logic [47:0]  tx_bits = '0;
    logic [5:0]   done_err = '0;
    logic [127:0] done_resp = '0;

    always @(posedge PCLK_i) begin
        if (sd_tick_i) tick_total <= tick_total + 1;
        if (sd_tick_i && cmd_oe_o) begin
            tx_bits      <= {tx_bits[46:0], cmd_o};
            tx_cnt       <= tx_cnt + 1;
            tx_last_tick <= tick_total + 1;
        end
        if (done_o) begin
            done_cnt  <= done_cnt + 1;
            done_err  <= err_o;
            done_resp <= resp_o;
            done_tick <= tick_total;
        end
        if (done_o && cmd_ready_o) overlap_cnt <= overlap_cnt + 1;
        if (cmd_valid_i && cmd_ready_o) accept_tick <= tick_total;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7_model(input logic [127:0] data, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] build_r1(input logic [5:0] idx, input logic [31:0] st);
        logic [39:0] h;
        h = {2'b00, idx, st};
        return {h, crc7_model({88'd0, h}, 40), 1'b1};
    endfunction

    task automatic wait_tick();
        do @(posedge PCLK_i); while (!sd_tick_i);
        #1;
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] rt,
                         input logic [15:0] tmo, input logic [23:0] bl);
        int n;
        n = 0;
        cmd_index_i = idx; cmd_arg_i = arg; resp_type_i = rt;
        timeout_i = tmo; busy_limit_i = bl; cmd_valid_i = 1'b1;
        do begin @(posedge PCLK_i); n++; end while (!cmd_ready_o && n < 5000);
        #1 cmd_valid_i = 1'b0;
        if (n >= 5000) check("accept_bound", 128'(n), 128'(0));
    endtask

    task automatic wait_release(input int prev_tx);
        int n;
        n = 0;
        while ((cmd_oe_o !== 1'b0 || tx_cnt < prev_tx + 48) && n < 5000) begin
            @(negedge PCLK_i); n++;
        end
        check("release_seen", 128'(tx_cnt - prev_tx), 128'(48));
    endtask

    task automatic wait_done(input int prev, input string name);
        int n;
        n = 0;
        while (done_cnt == prev && n < 20000) begin @(negedge PCLK_i); n++; end
        check({name, "_done"}, 128'(done_cnt - prev), 128'(1));
        $display("txn %s: err=%b resp=%0h tick=%0d", name, done_err, done_resp, done_tick);
    endtask

    task automatic send_resp(input logic [135:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cmd_i = bits[i];
            wait_tick();
        end
        cmd_i = 1'b1;
    endtask

    initial begin
        int          ptx, pdn, ref_tick;
        logic [47:0] r48;
        logic [119:0] cid;
        logic [135:0] r136;

        repeat (3) @(negedge PCLK_i);
        check("rst_cmd_o", 128'(cmd_o), 128'(1));
        check("rst_oe", 128'(cmd_oe_o), 128'(0));
        check("rst_ready", 128'(cmd_ready_o), 128'(0));
        check("rst_done", 128'(done_o), 128'(0));
        check("rst_resp", resp_o, 128'(0));
        check("rst_err", 128'(err_o), 128'(0));
        @(posedge PCLK_i); #1 PRESET_i = 1'b0;
        @(negedge PCLK_i);
        check("ready_after_rst", 128'(cmd_ready_o), 128'(1));

        // CMD0, no response
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd0, 32'd0, 3'd0, 16'd100, 24'd0);
        wait_done(pdn, "cmd0");
        check("cmd0_bits", 128'(tx_bits), 128'(48'h400000000095));
        check("cmd0_len", 128'(tx_cnt - ptx), 128'(48));
        check("cmd0_err", 128'(done_err), 128'(0));

        // CMD8 R1, issued during the gap
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd8, 32'h000001AA, 3'd1, 16'd100, 24'd0);
        check("ncc_gap", 128'(accept_tick - done_tick >= 8), 128'(1));
        wait_release(ptx);
        check("cmd8_bits", 128'(tx_bits), 128'(48'h48000001AA87));
        send_resp(136'(48'h08000001AA13), 48);
        wait_done(pdn, "cmd8");
        check("cmd8_resp", done_resp, 128'(38'h08000001AA));
        check("cmd8_err", 128'(done_err), 128'(0));

        // Corrupted argument bit -> CRC error
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd8, 32'h000001AA, 3'd1, 16'd100, 24'd0);
        wait_release(ptx);
        send_resp(136'(48'h08000001AB13), 48);
        wait_done(pdn, "cmd8_crc");
        check("crc_err", 128'(done_err), 128'(6'b000010));

        // End bit 0
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd8, 32'h000001AA, 3'd1, 16'd100, 24'd0);
        wait_release(ptx);
        send_resp(136'(48'h08000001AA12), 48);
        wait_done(pdn, "cmd8_end");
        check("end_err", 128'(done_err), 128'(6'b000100));
        check("end_resp", done_resp, 128'(38'h08000001AA));

        // Wrong index with valid CRC
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd8, 32'h000001AA, 3'd1, 16'd100, 24'd0);
        wait_release(ptx);
        send_resp(136'(build_r1(6'd9, 32'h000001AA)), 48);
        wait_done(pdn, "cmd8_idx");
        check("idx_err", 128'(done_err), 128'(6'b001000));

        // Response timeout at 64 ticks
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd8, 32'h000001AA, 3'd1, 16'd64, 24'd0);
        wait_release(ptx);
        ref_tick = tx_last_tick;
        wait_done(pdn, "timeout");
        check("tmo_err", 128'(done_err), 128'(6'b000001));
        check("tmo_ticks", 128'(done_tick - ref_tick), 128'(64));

        // CMD7 R1b, busy released after 100 ticks
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd7, 32'h12340000, 3'd2, 16'd100, 24'd1000);
        wait_release(ptx);
        dat0_i = 1'b0;
        send_resp(136'(build_r1(6'd7, 32'h00000700)), 48);
        repeat (100) wait_tick();
        check("busy_no_early_done", 128'(done_cnt - pdn), 128'(0));
        dat0_i = 1'b1;
        ref_tick = tick_total;
        wait_done(pdn, "busy_ok");
        check("busy_err", 128'(done_err), 128'(0));
        check("busy_delay", 128'(done_tick - ref_tick), 128'(1));
        check("busy_resp", done_resp, 128'({6'd7, 32'h00000700}));

        // R1b busy limit 50
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd7, 32'h12340000, 3'd2, 16'd100, 24'd50);
        wait_release(ptx);
        dat0_i = 1'b0;
        send_resp(136'(build_r1(6'd7, 32'h00000700)), 48);
        ref_tick = tick_total;
        wait_done(pdn, "busy_tmo");
        dat0_i = 1'b1;
        check("busy_tmo_err", 128'(done_err), 128'(6'b010000));
        check("busy_tmo_ticks", 128'(done_tick - ref_tick), 128'(50));

        // R3: no CRC/index check
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd41, 32'h40FF8000, 3'd4, 16'd100, 24'd0);
        wait_release(ptx);
        r48 = {2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1};
        send_resp(136'(r48), 48);
        wait_done(pdn, "r3");
        check("r3_err", 128'(done_err), 128'(0));
        check("r3_resp", done_resp, 128'(38'h3F80FF8000));

        // R2 CID
        cid  = 120'h1D4144534431323334D2B1C3_00A5F7;
        r136 = {2'b00, 6'h3F, cid, crc7_model({8'd0, cid}, 120), 1'b1};
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd2, 32'd0, 3'd3, 16'd100, 24'd0);
        wait_release(ptx);
        send_resp(r136, 136);
        wait_done(pdn, "r2");
        check("r2_err", 128'(done_err), 128'(0));
        check("r2_resp", done_resp, r136[127:0]);

        // Abort at RECV bit 60
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd2, 32'd0, 3'd3, 16'd100, 24'd0);
        wait_release(ptx);
        for (int i = 135; i >= 76; i--) begin
            cmd_i = r136[i];
            wait_tick();
        end
        abort_i = 1'b1;
        wait_done(pdn, "abort");
        check("abort_err", 128'(done_err), 128'(6'b100000));
        check("abort_oe", 128'(cmd_oe_o), 128'(0));
        check("abort_resp", done_resp, 128'(0));
        abort_i = 1'b0;
        cmd_i   = 1'b1;

        // Unknown response type behaves as NONE; also checks ready after abort gap
        ptx = tx_cnt; pdn = done_cnt;
        issue(6'd0, 32'd0, 3'd7, 16'd100, 24'd0);
        check("abort_gap", 128'(accept_tick - done_tick >= 8), 128'(1));
        wait_done(pdn, "type7");
        check("type7_bits", 128'(tx_bits), 128'(48'h400000000095));
        check("type7_err", 128'(done_err), 128'(0));

        // Reset in the middle of SEND
        wait_release(tx_cnt - 48);
        repeat (12) wait_tick();
        issue(6'd0, 32'd0, 3'd0, 16'd100, 24'd0);
        repeat (10) wait_tick();
        check("mid_oe_before", 128'(cmd_oe_o), 128'(1));
        pdn = done_cnt;
        PRESET_i = 1'b1;
        @(posedge PCLK_i); #1;
        check("mid_rst_oe", 128'(cmd_oe_o), 128'(0));
        check("mid_rst_cmd", 128'(cmd_o), 128'(1));
        check("mid_rst_ready", 128'(cmd_ready_o), 128'(0));
        PRESET_i = 1'b0;
        repeat (60) wait_tick();
        check("mid_rst_no_done", 128'(done_cnt - pdn), 128'(0));
        check("mid_rst_idle", 128'(cmd_ready_o), 128'(1));

        check("done_ready_overlap", 128'(overlap_cnt), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
